// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that shares one synchronous FIFO write port between
//   NUM_REQ producers. Each grant is a burst of up to MAX_BURST beats. The
//   FIFO full/almostfull flags hold the burst off. The write toward the FIFO
//   is registered. A sticky overflow error is kept, and accepted beats are
//   counted.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req[i]            requester i has a beat on req_data slice i
//   req_data          NUM_REQ slices of FIFO_WIDTH bits
//   req_last[i]       the current beat is the final beat of requester i's burst
//   gnt               one-hot current owner (registered), zero when idle
//   accept[i]         beat of requester i consumed this cycle (combinational)
//   fifo_wr_en        FIFO write enable (registered)
//   fifo_data_in      FIFO write data (registered)
//   fifo_full         FIFO full
//   fifo_almostfull   FIFO one slot from full
//   fifo_overflow     FIFO rejected a write
//   err_overflow      sticky: fifo_overflow seen since reset
//   beat_count        accepted beats, wraps at 2^16
//   state_dbg         FSM state (0 = IDLE, 1 = BURST)
//
// Handshake: a beat moves when req[o] and accept[o] are both high in the same
//   cycle. accept is only ever raised for the granted owner. A requester keeps
//   req and its data stable until it sees accept. Dropping req while granted
//   ends the burst at the next edge.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            accept,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_overflow,
  output logic                          err_overflow,
  output logic [15:0]                   beat_count,
  output logic                          state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BC_W-1:0]    BURST_END = BC_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       last_owner;
  logic [BC_W-1:0]        burst_cnt;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand;
  logic                   stall;
  logic                   beat_acc;
  logic                   burst_done;
  logic [FIFO_WIDTH-1:0]  owner_data;

  assign state_dbg = state;

  // Round-robin search starting just after last_owner. The loop walks from
  // the farthest candidate to the nearest, so the nearest requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Owner's data slice, selected with constant slices only.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) owner_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // almostfull together with a write already in flight means the FIFO will be
  // full by the time the next write lands, so hold this beat back.
  assign stall      = fifo_full | (fifo_almostfull & fifo_wr_en);
  assign beat_acc   = (state == BURST) & req[owner] & ~stall;
  assign burst_done = (beat_acc & (req_last[owner] | (burst_cnt == BURST_END))) | ~req[owner];

  always_comb begin
    accept = '0;
    if (beat_acc) accept[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gnt          <= '0;
      owner        <= '0;
      last_owner   <= LAST_INIT;
      burst_cnt    <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      err_overflow <= 1'b0;
      beat_count   <= '0;
    end else begin
      if (fifo_overflow) err_overflow <= 1'b1;
      fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt       <= ONE_HOT0 << pick_idx;
            owner     <= pick_idx;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (beat_acc) begin
            fifo_wr_en   <= 1'b1;
            fifo_data_in <= owner_data;
            beat_count   <= beat_count + 16'd1;
            burst_cnt    <= burst_cnt + 1'b1;
          end
          if (burst_done) begin
            gnt        <= '0;
            last_owner <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*W-1:0] req_data = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] gnt;
  logic [NR-1:0] accept;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_data_in;
  logic          fifo_full;
  logic          fifo_almostfull;
  logic          fifo_overflow;
  logic          err_overflow;
  logic [15:0]   beat_count;
  logic          state_dbg;

  // Small FIFO flag model: depth 8, no reads. Disabled flags read as 0.
  logic          model_en  = 1'b0;
  logic          ovf_force = 1'b0;
  logic [4:0]    fcnt;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .accept(accept), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull), .fifo_overflow(fifo_overflow),
    .err_overflow(err_overflow), .beat_count(beat_count), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) fcnt <= '0;
    else if (fifo_wr_en && fcnt < 5'd8) fcnt <= fcnt + 5'd1;
  end

  assign fifo_full       = model_en && (fcnt == 5'd8);
  assign fifo_almostfull = model_en && (fcnt == 5'd7);
  assign fifo_overflow   = ovf_force || (model_en && fifo_wr_en && (fcnt == 5'd8));

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_last = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_cmp++; if (fifo_data_in !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", fifo_data_in); end
    n_cmp++; if (beat_count !== 16'd0) begin n_bad++; $display("FAIL reset_beats: got %0d want 0", beat_count); end
    n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_overflow); end
    n_cmp++; if (state_dbg !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %b want 0", state_dbg); end
    rst = 1'b0;
  endtask

  // Single requester, 3-beat burst ending on req_last.
  task automatic test_single_burst();
    req = 4'b0001; req_data[15:0] = 16'hA001; req_last = '0;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL t1_gnt: got %b want 0001", gnt); end
    n_cmp++; if (accept !== 4'b0001) begin n_bad++; $display("FAIL t1_accept: got %b want 0001", accept); end
    @(negedge clk);
    n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'hA001) begin n_bad++; $display("FAIL t1_beat1: got en=%b data=%h want en=1 data=a001", fifo_wr_en, fifo_data_in); end
    req_data[15:0] = 16'hA002;
    @(negedge clk);
    n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'hA002) begin n_bad++; $display("FAIL t1_beat2: got en=%b data=%h want en=1 data=a002", fifo_wr_en, fifo_data_in); end
    req_data[15:0] = 16'hA003; req_last = 4'b0001;
    @(negedge clk);
    n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'hA003) begin n_bad++; $display("FAIL t1_beat3: got en=%b data=%h want en=1 data=a003", fifo_wr_en, fifo_data_in); end
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL t1_gnt_end: got %b want 0000", gnt); end
    n_cmp++; if (beat_count !== 16'd3) begin n_bad++; $display("FAIL t1_beats: got %0d want 3", beat_count); end
    req = '0; req_last = '0;
    @(negedge clk);
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL t1_wr_idle: got %b want 0", fifo_wr_en); end
    n_cmp++; if (state_dbg !== 1'b0) begin n_bad++; $display("FAIL t1_state_idle: got %b want 0", state_dbg); end
  endtask

  // All four requesting, no last: 4-beat bursts, one idle cycle between.
  task automatic test_round_robin();
    logic [NR-1:0] exp_g;
    do_reset();
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 16'hB000 + 16'(i);
    req = 4'b1111; req_last = '0;
    for (int c = 0; c < 25; c++) begin
      int phase;
      int own;
      @(negedge clk);
      phase = c % 5;
      own   = (c / 5) % NR;
      exp_g = (phase < 4) ? 4'(1 << own) : 4'b0000;
      n_cmp++; if (gnt !== exp_g) begin n_bad++; $display("FAIL t2_gnt c=%0d: got %b want %b", c, gnt, exp_g); end
      n_cmp++; if (fifo_wr_en !== (phase >= 1)) begin n_bad++; $display("FAIL t2_wr_en c=%0d: got %b want %b", c, fifo_wr_en, phase >= 1); end
      if (phase >= 1) begin
        n_cmp++; if (fifo_data_in !== 16'hB000 + 16'(own)) begin n_bad++; $display("FAIL t2_data c=%0d: got %h want %h", c, fifo_data_in, 16'hB000 + 16'(own)); end
      end
    end
    n_cmp++; if (beat_count !== 16'd20) begin n_bad++; $display("FAIL t2_beats: got %0d want 20", beat_count); end
    req = '0;
  endtask

  // Depth-8 FIFO, never read: exactly 8 writes, then held off.
  task automatic test_backpressure();
    int writes;
    logic saw_ovf;
    writes = 0; saw_ovf = 1'b0;
    model_en = 1'b1;
    do_reset();
    req = 4'b0001; req_data[15:0] = 16'hC0DE; req_last = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      if (fifo_overflow) saw_ovf = 1'b1;
    end
    n_cmp++; if (writes != 8) begin n_bad++; $display("FAIL t3_writes: got %0d want 8", writes); end
    n_cmp++; if (accept !== 4'b0000) begin n_bad++; $display("FAIL t3_accept_full: got %b want 0000", accept); end
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL t3_gnt_held: got %b want 0001", gnt); end
    n_cmp++; if (saw_ovf !== 1'b0) begin n_bad++; $display("FAIL t3_overflow: got %b want 0", saw_ovf); end
    n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL t3_err: got %b want 0", err_overflow); end
    n_cmp++; if (beat_count !== 16'd8) begin n_bad++; $display("FAIL t3_beats: got %0d want 8", beat_count); end
    req = '0; model_en = 1'b0;
  endtask

  // Sticky overflow error.
  task automatic test_overflow_sticky();
    do_reset();
    @(negedge clk);
    n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL t4_err_pre: got %b want 0", err_overflow); end
    ovf_force = 1'b1;
    @(negedge clk);
    ovf_force = 1'b0;
    n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL t4_err_set: got %b want 1", err_overflow); end
    repeat (3) @(negedge clk);
    n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL t4_err_hold: got %b want 1", err_overflow); end
    do_reset();
    n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL t4_err_clr: got %b want 0", err_overflow); end
  endtask

  // Reset on the 2nd beat, then regrant from req[0]; then owner withdraws.
  task automatic test_reset_mid_burst_and_withdraw();
    do_reset();
    req = 4'b0100; req_data[2*W +: W] = 16'hD002; req_last = '0;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL t5_gnt: got %b want 0100", gnt); end
    @(negedge clk);
    n_cmp++; if (fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL t5_beat1: got %b want 1", fifo_wr_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL t5_gnt_rst: got %b want 0000", gnt); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL t5_wr_rst: got %b want 0", fifo_wr_en); end
    n_cmp++; if (beat_count !== 16'd0) begin n_bad++; $display("FAIL t5_beats_rst: got %0d want 0", beat_count); end
    req = 4'b1101;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL t5_regrant: got %b want 0001", gnt); end
    // Owner 0 withdraws before any beat.
    req = 4'b1100;
    #1;
    n_cmp++; if (accept !== 4'b0000) begin n_bad++; $display("FAIL t6_accept_wd: got %b want 0000", accept); end
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000 || state_dbg !== 1'b0) begin n_bad++; $display("FAIL t6_idle: got gnt=%b st=%b want gnt=0000 st=0", gnt, state_dbg); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL t6_wr: got %b want 0", fifo_wr_en); end
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL t6_next_owner: got %b want 0100", gnt); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_overflow_sticky();
    test_reset_mid_burst_and_withdraw();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
